// File: rtl/vga_clut_arb.sv
// Single-port CLUT RAM arbiter: real-time pixel reads take priority over host
// Wishbone accesses, with a bounded-wait counter guaranteeing host progress.
module vga_clut_arb #(
   parameter int AW            = 8,
   parameter int DW            = 24,
   parameter int MAX_HOST_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clut_req,
   input  logic [AW-1:0] clut_offs,
   output logic          clut_ack,
   output logic [DW-1:0] clut_q,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   output logic          wb_ack_o,
   output logic [DW-1:0] wb_dat_o,
   output logic          mem_ce,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_d,
   input  logic [DW-1:0] mem_q
);

   localparam int WCW = (MAX_HOST_WAIT < 1) ? 1 : $clog2(MAX_HOST_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_HOST_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_PIX  = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

   state_t          state_r, state_s;
   owner_t          owner_r, owner_s;
   logic [WCW-1:0]  wait_cnt_r, wait_cnt_s;
   logic            mem_ce_s, mem_we_s;
   logic [AW-1:0]   mem_adr_s;
   logic [DW-1:0]   mem_d_s;
   logic            clut_ack_s, wb_ack_s;
   logic            hreq_s, preq_s, at_max_s, host_win_s;

   // Read data is passed straight from the RAM; only the matching ack qualifies it.
   assign clut_q   = mem_q;
   assign wb_dat_o = mem_q;

   assign hreq_s     = wb_cyc_i & wb_stb_i;
   assign preq_s     = clut_req;
   assign at_max_s   = (wait_cnt_r == WAIT_MAX);
   assign host_win_s = hreq_s & (~preq_s | at_max_s);

   // Next-state and next-output decode for the IDLE -> ACC -> ACK sequence.
   always_comb begin
      state_s    = state_r;
      owner_s    = owner_r;
      wait_cnt_s = wait_cnt_r;
      mem_ce_s   = mem_ce;
      mem_we_s   = mem_we;
      mem_adr_s  = mem_adr;
      mem_d_s    = mem_d;
      clut_ack_s = clut_ack;
      wb_ack_s   = wb_ack_o;
      case (state_r)
         ST_IDLE: begin
            clut_ack_s = 1'b0;
            wb_ack_s   = 1'b0;
            if (host_win_s) begin
               mem_ce_s   = 1'b1;
               mem_we_s   = wb_we_i;
               mem_adr_s  = wb_adr_i;
               mem_d_s    = wb_dat_i;
               owner_s    = OWN_HOST;
               wait_cnt_s = '0;
               state_s    = ST_ACC;
            end else if (preq_s) begin
               mem_ce_s  = 1'b1;
               mem_we_s  = 1'b0;
               mem_adr_s = clut_offs;
               mem_d_s   = wb_dat_i;
               owner_s   = OWN_PIX;
               state_s   = ST_ACC;
               // Count pixel grants that made a waiting host stand aside.
               if (hreq_s && !at_max_s) begin
                  wait_cnt_s = wait_cnt_r + WCW'(1);
               end else begin
                  wait_cnt_s = wait_cnt_r;
               end
            end else begin
               mem_ce_s = 1'b0;
               mem_we_s = 1'b0;
            end
         end
         ST_ACC: begin
            mem_ce_s   = 1'b0;
            mem_we_s   = 1'b0;
            clut_ack_s = (owner_r == OWN_PIX);
            wb_ack_s   = (owner_r == OWN_HOST);
            state_s    = ST_ACK;
         end
         ST_ACK: begin
            clut_ack_s = 1'b0;
            wb_ack_s   = 1'b0;
            state_s    = ST_IDLE;
         end
         default: begin
            mem_ce_s   = 1'b0;
            mem_we_s   = 1'b0;
            clut_ack_s = 1'b0;
            wb_ack_s   = 1'b0;
            state_s    = ST_IDLE;
         end
      endcase
   end

   // State, arbitration bookkeeping and registered RAM/ack outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         owner_r    <= OWN_PIX;
         wait_cnt_r <= '0;
         mem_ce     <= 1'b0;
         mem_we     <= 1'b0;
         mem_adr    <= '0;
         mem_d      <= '0;
         clut_ack   <= 1'b0;
         wb_ack_o   <= 1'b0;
      end else begin
         state_r    <= state_s;
         owner_r    <= owner_s;
         wait_cnt_r <= wait_cnt_s;
         mem_ce     <= mem_ce_s;
         mem_we     <= mem_we_s;
         mem_adr    <= mem_adr_s;
         mem_d      <= mem_d_s;
         clut_ack   <= clut_ack_s;
         wb_ack_o   <= wb_ack_s;
      end
   end

endmodule

// File: tb/tb_vga_clut_arb.sv
// Directed bench for vga_clut_arb: one instance with MAX_HOST_WAIT=4 (a_*), one with 0 (b_*),
// sharing stimulus, each with its own synchronous RAM model.
module tb_vga_clut_arb;

   logic        clk, rst;
   logic        clut_req;
   logic [7:0]  clut_offs;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [7:0]  wb_adr_i;
   logic [23:0] wb_dat_i;

   logic        a_clut_ack, a_wb_ack, a_mem_ce, a_mem_we;
   logic [23:0] a_clut_q, a_wb_dat, a_mem_d, a_mem_q;
   logic [7:0]  a_mem_adr;
   logic        b_clut_ack, b_wb_ack, b_mem_ce, b_mem_we;
   logic [23:0] b_clut_q, b_wb_dat, b_mem_d, b_mem_q;
   logic [7:0]  b_mem_adr;

   logic [23:0] ram_a [256];
   logic [23:0] ram_b [256];

   int checks = 0;
   int errors = 0;

   vga_clut_arb #(.AW(8), .DW(24), .MAX_HOST_WAIT(4)) dut_a (
      .clk(clk), .rst(rst), .clut_req(clut_req), .clut_offs(clut_offs),
      .clut_ack(a_clut_ack), .clut_q(a_clut_q),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(a_wb_ack), .wb_dat_o(a_wb_dat),
      .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_adr(a_mem_adr), .mem_d(a_mem_d),
      .mem_q(a_mem_q)
   );

   vga_clut_arb #(.AW(8), .DW(24), .MAX_HOST_WAIT(0)) dut_b (
      .clk(clk), .rst(rst), .clut_req(clut_req), .clut_offs(clut_offs),
      .clut_ack(b_clut_ack), .clut_q(b_clut_q),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(b_wb_ack), .wb_dat_o(b_wb_dat),
      .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_adr(b_mem_adr), .mem_d(b_mem_d),
      .mem_q(b_mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM models; palette entry 0x80 is preloaded while reset is held.
   always @(posedge clk) begin
      if (rst) begin
         ram_a[8'h80] <= 24'hAABBCC;
         ram_b[8'h80] <= 24'hAABBCC;
      end else begin
         if (a_mem_ce) begin
            if (a_mem_we) ram_a[a_mem_adr] <= a_mem_d;
            a_mem_q <= ram_a[a_mem_adr];
         end
         if (b_mem_ce) begin
            if (b_mem_we) ram_b[b_mem_adr] <= b_mem_d;
            b_mem_q <= ram_b[b_mem_adr];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit seen_ack;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({a_mem_ce, a_mem_we, a_clut_ack, a_wb_ack} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 0000", {a_mem_ce, a_mem_we, a_clut_ack, a_wb_ack});
      end
      checks++;
      if ({a_mem_adr, a_mem_d} !== 32'h0) begin
         errors++;
         $display("FAIL reset_adr_d got %h exp 00000000", {a_mem_adr, a_mem_d});
      end
      rst = 1'b0;
      tick();
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h33;
      tick();
      checks++;
      if (a_mem_ce !== 1'b1 || a_mem_adr !== 8'h33) begin
         errors++;
         $display("FAIL rst_mid_grant got ce=%b adr=%h exp ce=1 adr=33", a_mem_ce, a_mem_adr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({a_mem_ce, a_clut_ack, a_wb_ack, a_mem_adr} !== 11'h0) begin
         errors++;
         $display("FAIL rst_mid_async got ce=%b ack=%b%b adr=%h exp 0", a_mem_ce, a_clut_ack, a_wb_ack, a_mem_adr);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      seen_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (a_wb_ack || a_mem_ce) seen_ack = 1'b1;
      end
      checks++;
      if (seen_ack !== 1'b0) begin
         errors++;
         $display("FAIL rst_dropped got activity=%b exp 0", seen_ack);
      end
   endtask

   task automatic test_host_write_read();
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 8'h05; wb_dat_i = 24'h123456;
      tick();
      checks++;
      if ({a_mem_ce, a_mem_we, a_mem_adr, a_mem_d} !== {1'b1, 1'b1, 8'h05, 24'h123456}) begin
         errors++;
         $display("FAIL wr_acc got ce=%b we=%b adr=%h d=%h exp 1 1 05 123456", a_mem_ce, a_mem_we, a_mem_adr, a_mem_d);
      end
      tick();
      checks++;
      if ({a_wb_ack, a_mem_ce, a_mem_we} !== 3'b100) begin
         errors++;
         $display("FAIL wr_ack got ack=%b ce=%b we=%b exp 1 0 0", a_wb_ack, a_mem_ce, a_mem_we);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 24'h0;
      tick();
      checks++;
      if ({a_wb_ack, a_mem_we} !== 2'b00) begin
         errors++;
         $display("FAIL wr_done got ack=%b we=%b exp 0 0", a_wb_ack, a_mem_we);
      end
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 8'h05;
      tick();
      checks++;
      if ({a_mem_ce, a_mem_we, a_wb_ack} !== 3'b100) begin
         errors++;
         $display("FAIL rd_acc got ce=%b we=%b ack=%b exp 1 0 0", a_mem_ce, a_mem_we, a_wb_ack);
      end
      tick();
      checks++;
      if (a_wb_ack !== 1'b1 || a_wb_dat !== 24'h123456) begin
         errors++;
         $display("FAIL rd_ack got ack=%b dat=%h exp 1 123456", a_wb_ack, a_wb_dat);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
   endtask

   task automatic test_pixel_read();
      int acks;
      clut_req = 1'b1; clut_offs = 8'h80;
      tick();
      checks++;
      if ({a_mem_ce, a_mem_we, a_mem_adr, a_clut_ack} !== {1'b1, 1'b0, 8'h80, 1'b0}) begin
         errors++;
         $display("FAIL pix_acc got ce=%b we=%b adr=%h ack=%b exp 1 0 80 0", a_mem_ce, a_mem_we, a_mem_adr, a_clut_ack);
      end
      tick();
      checks++;
      if (a_clut_ack !== 1'b1 || a_clut_q !== 24'hAABBCC || a_wb_ack !== 1'b0) begin
         errors++;
         $display("FAIL pix_ack got ack=%b q=%h wb=%b exp 1 aabbcc 0", a_clut_ack, a_clut_q, a_wb_ack);
      end
      // Held request: acks must land exactly every third cycle.
      acks = 0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (a_clut_ack) acks++;
         checks++;
         if (a_clut_ack !== ((i % 3) == 0)) begin
            errors++;
            $display("FAIL pix_rate cyc %0d got ack=%b exp %b", i, a_clut_ack, ((i % 3) == 0));
         end
      end
      checks++;
      if (acks != 3) begin
         errors++;
         $display("FAIL pix_count got %0d exp 3", acks);
      end
      // Now in an ACK cycle: drop the request and the arbiter must go quiet.
      clut_req = 1'b0;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (a_mem_ce || a_clut_ack) acks++;
      end
      checks++;
      if (acks != 0 || a_mem_adr !== 8'h80) begin
         errors++;
         $display("FAIL pix_drop got activity=%0d adr=%h exp 0 80", acks, a_mem_adr);
      end
   endtask

   task automatic test_contention();
      int pre, post, host, both;
      pre = 0; post = 0; host = 0; both = 0;
      clut_req = 1'b1; clut_offs = 8'h80;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h05;
      for (int i = 1; i < 40; i++) begin
         tick();
         if (a_clut_ack && a_wb_ack) both++;
         if (a_clut_ack) begin
            if (host == 0) pre++;
            else post++;
         end
         if (a_wb_ack) begin
            host++;
            checks++;
            if (a_wb_dat !== 24'h123456) begin
               errors++;
               $display("FAIL cont_data got %h exp 123456", a_wb_dat);
            end
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
         end
      end
      checks++;
      if (pre != 4 || host != 1 || post != 8 || both != 0) begin
         errors++;
         $display("FAIL contention got pre=%0d host=%0d post=%0d both=%0d exp 4 1 8 0", pre, host, post, both);
      end
      clut_req = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      // Counter must have restarted: a fresh host request again waits exactly 4 pixel grants.
      pre = 0; host = 0;
      clut_req = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      for (int i = 1; i < 20 && host == 0; i++) begin
         tick();
         if (a_clut_ack) pre++;
         if (a_wb_ack) begin
            host++;
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
         end
      end
      checks++;
      if (pre != 4 || host != 1) begin
         errors++;
         $display("FAIL cont_rewait got pre=%0d host=%0d exp 4 1", pre, host);
      end
      clut_req = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_max_wait_zero();
      clut_req = 1'b1; clut_offs = 8'h80;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h05;
      tick();
      checks++;
      if (b_mem_ce !== 1'b1 || b_mem_adr !== 8'h05) begin
         errors++;
         $display("FAIL mw0_grant got ce=%b adr=%h exp 1 05", b_mem_ce, b_mem_adr);
      end
      tick();
      checks++;
      if ({b_wb_ack, b_clut_ack} !== 2'b10 || b_wb_dat !== 24'h123456) begin
         errors++;
         $display("FAIL mw0_host got ack=%b%b dat=%h exp 10 123456", b_wb_ack, b_clut_ack, b_wb_dat);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      tick();
      checks++;
      if (b_mem_ce !== 1'b1 || b_mem_adr !== 8'h80) begin
         errors++;
         $display("FAIL mw0_pgrant got ce=%b adr=%h exp 1 80", b_mem_ce, b_mem_adr);
      end
      tick();
      checks++;
      if ({b_clut_ack, b_wb_ack} !== 2'b10 || b_clut_q !== 24'hAABBCC) begin
         errors++;
         $display("FAIL mw0_pix got ack=%b%b q=%h exp 10 aabbcc", b_clut_ack, b_wb_ack, b_clut_q);
      end
      clut_req = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      clut_req = 1'b0; clut_offs = 8'h00;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = 8'h00; wb_dat_i = 24'h0;
      test_reset();
      test_host_write_read();
      test_pixel_read();
      test_contention();
      test_max_wait_zero();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
